decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter: DEPTH, 4, queue entries; power of two, 2..16.
REQ-002 Parameter: ILL_CNT_W, 8, width of illegal-instruction counter.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  in  1  instruction word offered.
REQ-006 Port: in_instr  in  32  RV32 instruction word.
REQ-007 Port: in_ready  out  1  queue accepts a word this cycle.
REQ-008 Port: flush  in  1  synchronous discard of all queued entries.
REQ-009 Port: alu_ready, mul_ready, mem_ready  in  1 each  target reservation station has a free slot.
REQ-010 Port: iss_valid  out  1  head entry present.
REQ-011 Port: iss_class  out  2  00 ALU, 01 MUL, 10 LOAD, 11 STORE.
REQ-012 Port: iss_rd, iss_rs1, iss_rs2  out  5 each  register specifiers.
REQ-013 Port: iss_funct3  out  3  instr[14:12]; iss_alt  out  1  instr[30], SUB/SRA select.
REQ-014 Port: iss_imm  out  12  LOAD instr[31:20]; STORE {instr[31:25],instr[11:7]}; else 0.
REQ-015 Port: iss_fire  out  1  head dequeued this cycle.
REQ-016 Port: count  out  $clog2(DEPTH+1)  occupied entries.
REQ-017 Port: ill_cnt  out  ILL_CNT_W  illegal words consumed, saturating.

Function
REQ-018 Decode SHALL be combinational on in_instr; op = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25].
REQ-019 ALU: op 0110011, funct7 0000000 (any funct3), or funct7 0100000 with funct3 000 or 101.
REQ-020 MUL: op 0110011, funct7 0000001, any funct3.
REQ-021 LOAD: op 0000011, funct3 in {000,001,010,100,101}; rs2 field stored as 0.
REQ-022 STORE: op 0100011, funct3 in {000,001,010}; rd field stored as 0.
REQ-023 Any other word SHALL be illegal.
REQ-024 in_ready SHALL equal (count != DEPTH); no enqueue while full, even when the head dequeues the same cycle.
REQ-025 Accept = in_valid && in_ready && !flush; a legal accepted word is written at tail; count +1.
REQ-026 Illegal accepted word SHALL be consumed, not enqueued; ill_cnt +1, holding at all-ones.
REQ-027 iss_valid SHALL equal (count != 0); no bypass, so enqueue-to-iss_valid latency is 1 cycle.
REQ-028 iss_fire = iss_valid && !flush && ready of head class (ALU->alu_ready, MUL->mul_ready, LOAD/STORE->mem_ready).
REQ-029 Issue is strictly in order; a blocked head stalls younger entries.
REQ-030 Simultaneous enqueue and iss_fire SHALL leave count unchanged; head and tail pointers advance.
REQ-031 Pointers wrap modulo DEPTH.
REQ-032 All iss_* fields SHALL be 0 whenever iss_valid = 0.
REQ-033 flush SHALL take priority over enqueue and dequeue: next cycle count = 0, pointers = 0; ill_cnt unaffected; in_ready = 1 in the flush cycle is permitted but nothing is written.

Reset
REQ-034 rst_n low SHALL asynchronously clear pointers, count, ill_cnt; iss_valid = 0, iss_fire = 0, in_ready = 1, all iss_* fields 0.
REQ-035 Reset asserted mid-operation SHALL discard queued entries; first accept after release behaves as from empty.

Verification
REQ-036 Reset, push add x3,x1,x2 (0x002081B3), all ready=1 -> next cycle iss_valid=1, class 00, rd=3, rs1=1, rs2=2, iss_fire=1; following cycle count=0.
REQ-037 mem_ready=0, push lw x5,8(x6) (0x00832283) then mul x7,x1,x2 (0x022083B3), mul_ready=1 -> head LOAD imm=8 blocks, MUL not issued until mem_ready=1.
REQ-038 All ready=0, push DEPTH+1 legal words -> in_ready=0 at count=DEPTH; extra word held; one dequeue while in_valid=1 -> no same-cycle enqueue, accept next cycle.
REQ-039 Push 0x0000007F, then sw x2,4(x1) (0x0020A223) -> ill_cnt=1, only STORE queued, rd=0, imm=4; 300 illegal words -> ill_cnt=255.
REQ-040 Queue 3 entries, assert flush with in_valid=1 -> next cycle count=0, iss_valid=0, offered word dropped; reset pulse mid-stream -> same empty state.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: RV32 decode stage feeding an in-order issue FIFO.
// Incoming words are classified ALU/MUL/LOAD/STORE as they arrive. Legal
// words are queued already decoded; illegal words are dropped and counted.
// The head entry issues when the reservation station for its class has room.
module decode_queue #(
    parameter int DEPTH     = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [31:0]                  in_instr,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         alu_ready,
    input  logic                         mul_ready,
    input  logic                         mem_ready,
    output logic                         iss_valid,
    output logic [1:0]                   iss_class,
    output logic [4:0]                   iss_rd,
    output logic [4:0]                   iss_rs1,
    output logic [4:0]                   iss_rs2,
    output logic [2:0]                   iss_funct3,
    output logic                         iss_alt,
    output logic [11:0]                  iss_imm,
    output logic                         iss_fire,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ILL_CNT_W-1:0]         ill_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] C_ALU   = 2'b00;
    localparam logic [1:0] C_MUL   = 2'b01;
    localparam logic [1:0] C_LOAD  = 2'b10;
    localparam logic [1:0] C_STORE = 2'b11;

    // One decoded queue entry; field order mirrors the iss_* ports.
    typedef struct packed {
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic [11:0] imm;
    } entry_t;

    entry_t          dec;
    logic            dec_legal;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rptr, wptr;
    logic            accept, enq, head_rdy;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    // Combinational classification and field extraction of the offered word.
    always_comb begin
        dec_legal  = 1'b0;
        dec        = '0;
        dec.funct3 = f3;
        dec.alt    = in_instr[30];
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec_legal = 1'b1;
                    dec.cls   = C_ALU;
                end else if (f7 == 7'b0000001) begin
                    dec_legal = 1'b1;
                    dec.cls   = C_MUL;
                end
            end
            7'b0000011: begin
                if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                    dec_legal = 1'b1;
                    dec.cls   = C_LOAD;
                    dec.rs2   = '0;
                    dec.imm   = in_instr[31:20];
                end
            end
            7'b0100011: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec.cls   = C_STORE;
                    dec.rd    = '0;
                    dec.imm   = {in_instr[31:25], in_instr[11:7]};
                end
            end
            default: ;
        endcase
    end

    // Full check ignores a same-cycle dequeue so in_ready never depends on
    // the downstream ready inputs.
    assign in_ready  = (count != FULL);
    assign accept    = in_valid && in_ready && !flush;
    assign enq       = accept && dec_legal;

    assign head      = mem[rptr];
    assign iss_valid = (count != '0);

    // Pick the reservation-station ready matching the head's class.
    always_comb begin
        head_rdy = 1'b0;
        case (head.cls)
            C_ALU:   head_rdy = alu_ready;
            C_MUL:   head_rdy = mul_ready;
            default: head_rdy = mem_ready;
        endcase
    end

    assign iss_fire   = iss_valid && !flush && head_rdy;

    // Stale storage is never exposed: fields read zero while empty.
    assign iss_class  = iss_valid ? head.cls    : '0;
    assign iss_rd     = iss_valid ? head.rd     : '0;
    assign iss_rs1    = iss_valid ? head.rs1    : '0;
    assign iss_rs2    = iss_valid ? head.rs2    : '0;
    assign iss_funct3 = iss_valid ? head.funct3 : '0;
    assign iss_alt    = iss_valid ? head.alt    : 1'b0;
    assign iss_imm    = iss_valid ? head.imm    : '0;

    // Entry storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) mem[wptr] <= dec;
    end

    // Pointers and occupancy; flush wins over both enqueue and dequeue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq)      wptr <= wptr + 1'b1;
            if (iss_fire) rptr <= rptr + 1'b1;
            case ({enq, iss_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating count of consumed illegal words; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (accept && !dec_legal && ill_cnt != '1) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model evaluated at the falling edge.
module tb_decode_queue;

    localparam int DEPTH   = 4;
    localparam int ILL_W   = 8;
    localparam int ILL_MAX = (1 << ILL_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, alu_ready, mul_ready, mem_ready;
    logic [31:0] in_instr;
    logic        in_ready, iss_valid, iss_alt, iss_fire;
    logic [1:0]  iss_class;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [2:0]  iss_funct3;
    logic [11:0] iss_imm;
    logic [2:0]  count;
    logic [7:0]  ill_cnt;

    decode_queue #(.DEPTH(DEPTH), .ILL_CNT_W(ILL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush),
        .alu_ready(alu_ready), .mul_ready(mul_ready), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_class(iss_class), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_funct3(iss_funct3),
        .iss_alt(iss_alt), .iss_imm(iss_imm), .iss_fire(iss_fire),
        .count(count), .ill_cnt(ill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [11:0] imm;
    } ent_t;

    ent_t mq[$];
    int   mill;
    int   n_cmp = 0;
    int   n_err = 0;

    // falling-edge snapshot of the DUT for directed spot checks
    logic       s_v, s_rdy, s_fire;
    logic [1:0] s_cls;
    logic [4:0] s_rd, s_rs1, s_rs2;
    logic [11:0] s_imm;
    logic [2:0] s_cnt;
    logic [7:0] s_ill;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference classification straight from the ISA field rules.
    function automatic bit ref_dec(input logic [31:0] w, output ent_t e);
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        e = '{cls: 2'd0, rd: w[11:7], rs1: w[19:15], rs2: w[24:20],
              f3: w[14:12], alt: w[30], imm: 12'd0};
        if (op == 'h33 && (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)))) begin
            e.cls = 2'd0; return 1'b1;
        end
        if (op == 'h33 && f7 == 1) begin
            e.cls = 2'd1; return 1'b1;
        end
        if (op == 'h03 && (f3 <= 2 || f3 == 4 || f3 == 5)) begin
            e.cls = 2'd2; e.rs2 = 5'd0; e.imm = w[31:20]; return 1'b1;
        end
        if (op == 'h23 && f3 <= 2) begin
            e.cls = 2'd3; e.rd = 5'd0; e.imm = {w[31:25], w[11:7]}; return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_fire();
        if (mq.size() == 0 || flush) return 1'b0;
        case (mq[0].cls)
            2'd0:    return alu_ready;
            2'd1:    return mul_ready;
            default: return mem_ready;
        endcase
    endfunction

    task automatic check_model();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("count",     64'(count),     64'(mq.size()));
        chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
        chk("iss_valid", 64'(iss_valid), 64'(mq.size() != 0));
        chk("iss_fields",
            64'({iss_class, iss_rd, iss_rs1, iss_rs2, iss_funct3, iss_alt, iss_imm}),
            64'(h));
        chk("iss_fire",  64'(iss_fire),  64'(exp_fire()));
        chk("ill_cnt",   64'(ill_cnt),   64'(mill));
    endtask

    task automatic step_model();
        ent_t e;
        bit   ok, f;
        int   sz;
        sz = mq.size();
        f  = exp_fire();
        if (flush) begin
            mq.delete();
        end else begin
            if (f) void'(mq.pop_front());
            if (in_valid && sz != DEPTH) begin
                ok = ref_dec(in_instr, e);
                if (ok) mq.push_back(e);
                else if (mill < ILL_MAX) mill++;
            end
        end
    endtask

    // One clock: drive, check and snapshot at the falling edge, advance model.
    task automatic cyc(input logic v, input logic [31:0] w, input logic fl,
                       input logic ar, input logic mr, input logic er);
        in_valid = v; in_instr = w; flush = fl;
        alu_ready = ar; mul_ready = mr; mem_ready = er;
        @(negedge clk);
        s_v = iss_valid; s_rdy = in_ready; s_fire = iss_fire; s_cls = iss_class;
        s_rd = iss_rd; s_rs1 = iss_rs1; s_rs2 = iss_rs2; s_imm = iss_imm;
        s_cnt = count; s_ill = ill_cnt;
        check_model();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        chk("rst_count",  64'(count),     64'd0);
        chk("rst_valid",  64'(iss_valid), 64'd0);
        chk("rst_ready",  64'(in_ready),  64'd1);
        chk("rst_fire",   64'(iss_fire),  64'd0);
        chk("rst_ill",    64'(ill_cnt),   64'd0);
        chk("rst_fields",
            64'({iss_class, iss_rd, iss_rs1, iss_rs2, iss_funct3, iss_alt, iss_imm}),
            64'd0);
        mq.delete();
        mill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 5))
            0: ;
            1: w = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, w[24:7], 7'h33};
            2: w = {7'h01, w[24:7], 7'h33};
            3: w = {w[31:7], 7'h03};
            4: w = {w[31:7], 7'h23};
            default: w = {w[31:7], 7'h33};
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        alu_ready = 1'b0; mul_ready = 1'b0; mem_ready = 1'b0;
        mill = 0;
        @(posedge clk);
        #1;
        do_reset();

        // single ALU op issues the cycle after enqueue
        cyc(1, 32'h002081B3, 0, 1, 1, 1);
        cyc(0, 32'h0, 0, 1, 1, 1);
        chk("add_valid", 64'(s_v), 64'd1);
        chk("add_class", 64'(s_cls), 64'd0);
        chk("add_regs",  64'({s_rd, s_rs1, s_rs2}), 64'({5'd3, 5'd1, 5'd2}));
        chk("add_fire",  64'(s_fire), 64'd1);
        cyc(0, 32'h0, 0, 1, 1, 1);
        chk("add_drain", 64'(s_cnt), 64'd0);

        // LOAD head blocks a younger MUL until memory is ready
        cyc(1, 32'h00832283, 0, 1, 1, 0);
        cyc(1, 32'h022083B3, 0, 1, 1, 0);
        cyc(0, 32'h0, 0, 1, 1, 0);
        chk("lw_class", 64'(s_cls), 64'd2);
        chk("lw_imm",   64'(s_imm), 64'd8);
        chk("lw_block", 64'(s_fire), 64'd0);
        cyc(0, 32'h0, 0, 1, 1, 0);
        chk("lw_hold",  64'(s_cnt), 64'd2);
        cyc(0, 32'h0, 0, 1, 1, 1);
        chk("lw_fire",  64'(s_fire), 64'd1);
        cyc(0, 32'h0, 0, 1, 1, 0);
        chk("mul_class", 64'(s_cls), 64'd1);
        chk("mul_fire",  64'(s_fire), 64'd1);
        cyc(0, 32'h0, 0, 1, 1, 0);

        // fill to DEPTH; a dequeue while full does not admit the waiting word
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(1, 32'h00208033 | ((i + 1) << 7), 0, 0, 0, 0);
        chk("full_rdy", 64'(s_rdy), 64'd0);
        chk("full_cnt", 64'(s_cnt), 64'(DEPTH));
        cyc(1, 32'h00208033 | ((DEPTH + 1) << 7), 0, 1, 0, 0);
        chk("full_deq_fire", 64'(s_fire), 64'd1);
        chk("full_deq_rdy",  64'(s_rdy), 64'd0);
        cyc(1, 32'h00208033 | ((DEPTH + 1) << 7), 0, 0, 0, 0);
        chk("after_deq_cnt", 64'(s_cnt), 64'(DEPTH - 1));
        chk("after_deq_rdy", 64'(s_rdy), 64'd1);
        cyc(0, 32'h0, 0, 0, 0, 0);
        chk("refill_cnt", 64'(s_cnt), 64'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 32'h0, 0, 1, 1, 1);

        // illegal word consumed, STORE queued, counter saturates
        cyc(1, 32'h0000007F, 0, 0, 0, 0);
        cyc(1, 32'h0020A223, 0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0, 0);
        chk("ill_one",  64'(s_ill), 64'd1);
        chk("sw_cnt",   64'(s_cnt), 64'd1);
        chk("sw_class", 64'(s_cls), 64'd3);
        chk("sw_rd",    64'(s_rd),  64'd0);
        chk("sw_imm",   64'(s_imm), 64'd4);
        cyc(0, 32'h0, 0, 1, 1, 1);
        for (int i = 0; i < 300; i++) cyc(1, 32'hFFFFFFFF, 0, 1, 1, 1);
        cyc(0, 32'h0, 0, 1, 1, 1);
        chk("ill_sat", 64'(s_ill), 64'd255);

        // flush with a word offered drops everything
        for (int i = 0; i < 3; i++) cyc(1, 32'h022083B3, 0, 0, 0, 0);
        cyc(1, 32'h002081B3, 1, 0, 0, 0);
        chk("flush_cnt_before", 64'(s_cnt), 64'd3);
        cyc(0, 32'h0, 0, 0, 0, 0);
        chk("flush_cnt",   64'(s_cnt), 64'd0);
        chk("flush_valid", 64'(s_v),   64'd0);
        chk("flush_ill",   64'(s_ill), 64'd255);

        // reset mid-stream, then behave as from empty
        cyc(1, 32'h002081B3, 0, 0, 0, 0);
        cyc(1, 32'h00832283, 0, 0, 0, 0);
        do_reset();
        cyc(1, 32'h022083B3, 0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0, 0);
        chk("post_rst_cnt",   64'(s_cnt), 64'd1);
        chk("post_rst_class", 64'(s_cls), 64'd1);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 31) == 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
